// File: rtl/div_pkg.sv
// Shared types and constants for the iterative non-restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } divState_t;

   // The quotient reported for a zero divisor is all ones at any width
   localparam logic DIV_ZERO_Q_FILL = 1'b1;

endpackage

// File: rtl/nonrestoring_step.sv
// One combinational non-restoring iteration: shift {R,Q}, add/subtract D, append quotient bit.
module nonrestoring_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_divExt;

   assign w_shift  = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
   assign w_divExt = {1'b0, i_div};

   // A negative partial remainder adds the divisor back instead of subtracting it
   assign o_rem = i_rem[WIDTH] ? (w_shift + w_divExt) : (w_shift - w_divExt);
   assign o_quo = {i_quo[WIDTH-2:0], ~o_rem[WIDTH]};

endmodule

// File: rtl/nonrestoring_divider.sv
// Iterative signed non-restoring divider returning {remainder, quotient} on a run/isValid handshake.
// Define DIV_UNSIGNED_EN to add the isSigned port for DIVU support.
import div_pkg::*;

module nonrestoring_divider #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   Dividend,
   input  logic [WIDTH-1:0]   Divisor,
   input  logic               run,
`ifdef DIV_UNSIGNED_EN
   input  logic               isSigned,
`endif
   output logic               isValid,
   output logic               divByZero,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   divState_t          r_state;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic               r_negQ;
   logic               r_negR;
   logic               r_divZero;
   logic [CW-1:0]      r_count;
   logic               r_valid;
   logic               r_dbz;
   logic [2*WIDTH-1:0] r_result;

   logic               w_signedOp;
   logic               w_dividendNeg;
   logic               w_divisorNeg;
   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic [WIDTH:0]     w_stepRem;
   logic [WIDTH-1:0]   w_stepQuo;
   logic [WIDTH-1:0]   w_fixRem;
   logic [WIDTH-1:0]   w_remOut;
   logic [WIDTH-1:0]   w_quoOut;

`ifdef DIV_UNSIGNED_EN
   assign w_signedOp = isSigned;
`else
   assign w_signedOp = 1'b1;
`endif

   assign w_dividendNeg = w_signedOp & Dividend[WIDTH-1];
   assign w_divisorNeg  = w_signedOp & Divisor[WIDTH-1];
   assign w_magA        = w_dividendNeg ? ('0 - Dividend) : Dividend;
   assign w_magB        = w_divisorNeg  ? ('0 - Divisor)  : Divisor;

   nonrestoring_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_stepRem),
      .o_quo (w_stepQuo)
   );

   // The corrected remainder lies in [0, divisor), so WIDTH-bit wraparound arithmetic is exact
   assign w_fixRem = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_div) : r_rem[WIDTH-1:0];
   assign w_remOut = r_negR ? ('0 - w_fixRem) : w_fixRem;
   assign w_quoOut = r_divZero ? {WIDTH{DIV_ZERO_Q_FILL}} :
                     (r_negQ ? ('0 - r_quo) : r_quo);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rem     <= '0;
         r_quo     <= '0;
         r_div     <= '0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
         r_divZero <= 1'b0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_dbz     <= 1'b0;
         r_result  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (run) begin
                  r_rem     <= '0;
                  r_quo     <= w_magA;
                  r_div     <= w_magB;
                  r_negQ    <= w_dividendNeg ^ w_divisorNeg;
                  r_negR    <= w_dividendNeg;
                  r_divZero <= (Divisor == '0);
                  r_count   <= '0;
                  r_state   <= CALC;
               end
            end
            CALC: begin
               if (!run) begin
                  r_state <= IDLE;
               end else begin
                  r_rem   <= w_stepRem;
                  r_quo   <= w_stepQuo;
                  r_count <= r_count + 1'b1;
                  if (r_count == CW'(WIDTH - 1)) begin
                     r_state <= FIX;
                  end
               end
            end
            FIX: begin
               if (!run) begin
                  r_state <= IDLE;
               end else begin
                  r_result <= {w_remOut, w_quoOut};
                  r_dbz    <= r_divZero;
                  r_valid  <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               if (!run) begin
                  r_valid <= 1'b0;
                  r_dbz   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign isValid   = r_valid;
   assign divByZero = r_dbz;
   assign result    = r_result;

endmodule
